// File: rtl/jtpopeye_pkg.sv
// jtpopeye_pkg
// Shared timing constants for the Popeye video timing generator, plus the
// bundle type used to carry the four decoded blank/sync flags.
// No ports.
package jtpopeye_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned HTOTAL_DEF   = 384;
    localparam int unsigned HB_START_DEF = 256;
    localparam int unsigned HB_END_DEF   = 0;
    localparam int unsigned HS_START_DEF = 300;
    localparam int unsigned HS_END_DEF   = 332;

    // Vertical timing, in lines
    localparam int unsigned VTOTAL_DEF   = 264;
    localparam int unsigned VB_START_DEF = 240;
    localparam int unsigned VB_END_DEF   = 8;
    localparam int unsigned VS_START_DEF = 244;
    localparam int unsigned VS_END_DEF   = 248;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs;
        logic vs;
    } vt_flags_t;

endpackage

// File: rtl/jtpopeye_vtiming_win.sv
// jtpopeye_vtiming_win
// Combinational window comparator: active is high for START <= pos < STOP.
// When START > STOP the window wraps through zero (pos >= START or pos < STOP).
// Ports:
//   pos    - counter value to test (W bits)
//   active - 1 when pos lies inside the window
import jtpopeye_pkg::*;

module jtpopeye_vtiming_win #(
    parameter int unsigned W     = 9,
    parameter int unsigned START = 0,
    parameter int unsigned STOP  = 0
) (
    input  logic [W-1:0] pos,
    output logic         active
);

    localparam logic [W-1:0] S = W'(START);
    localparam logic [W-1:0] E = W'(STOP);
    localparam bit WRAPS = (START > STOP);

    always_comb begin
        active = 1'b0;
        if (WRAPS) begin
            active = (pos >= S) || (pos < E);
        end else begin
            active = (pos >= S) && (pos < E);
        end
    end

endmodule

// File: rtl/jtpopeye_vtiming.sv
// jtpopeye_vtiming
// Video timing generator: raw and flip-adjusted pixel/line counters, blanking,
// sync, line/frame start strobes and frame parity. All state advances only on
// clk edges with pxl_cen high. Every registered flag is decoded from the
// counter value being loaded on the same edge, so flags never lag the counters.
// Optional feature: define JTPOPEYE_VTIMING_FLIP_EN to enable screen flip;
// otherwise flip is ignored and Hf/Vf mirror H/V.
// Ports:
//   clk, rst_n (async, active-low), pxl_cen (pixel enable), flip (flip request)
//   H, V       - raw pixel / line counters
//   Hf, Vf     - counters XORed with the frame-latched flip
//   HB, VB     - blanking (active high);  HS, VS - sync (active high)
//   hinit      - high while H=0;  vinit - high while H=0 and V=0
//   odd        - frame parity, toggles at each vinit
module jtpopeye_vtiming
    import jtpopeye_pkg::*;
#(
    parameter int unsigned HW       = 9,
    parameter int unsigned VW       = 9,
    parameter int unsigned HTOTAL   = HTOTAL_DEF,
    parameter int unsigned HB_START = HB_START_DEF,
    parameter int unsigned HB_END   = HB_END_DEF,
    parameter int unsigned HS_START = HS_START_DEF,
    parameter int unsigned HS_END   = HS_END_DEF,
    parameter int unsigned VTOTAL   = VTOTAL_DEF,
    parameter int unsigned VB_START = VB_START_DEF,
    parameter int unsigned VB_END   = VB_END_DEF,
    parameter int unsigned VS_START = VS_START_DEF,
    parameter int unsigned VS_END   = VS_END_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          flip,
    output logic [HW-1:0] H,
    output logic [VW-1:0] V,
    output logic [HW-1:0] Hf,
    output logic [VW-1:0] Vf,
    output logic          HB,
    output logic          VB,
    output logic          HS,
    output logic          VS,
    output logic          hinit,
    output logic          vinit,
    output logic          odd
);

    // Reject impossible timing at elaboration
    localparam bit BAD_H = (HTOTAL == 0) || (64'(HTOTAL) > (64'd1 << HW)) ||
                           (HB_START >= HTOTAL) || (HB_END >= HTOTAL) ||
                           (HS_START >= HTOTAL) || (HS_END >= HTOTAL);
    localparam bit BAD_V = (VTOTAL == 0) || (64'(VTOTAL) > (64'd1 << VW)) ||
                           (VB_START >= VTOTAL) || (VB_END >= VTOTAL) ||
                           (VS_START >= VTOTAL) || (VS_END >= VTOTAL);

    generate
        if (BAD_H || BAD_V) begin : g_bad_params
            $error("jtpopeye_vtiming: illegal timing parameter set");
        end
    endgenerate

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          hinit_nxt;
    logic          vinit_nxt;
    vt_flags_t     flags_nxt;

    always_comb begin
        h_nxt = H + HW'(1);
        v_nxt = V;
        if (H == H_LAST) begin
            h_nxt = '0;
            v_nxt = (V == V_LAST) ? '0 : V + VW'(1);
        end
        hinit_nxt = (h_nxt == '0);
        vinit_nxt = hinit_nxt && (v_nxt == '0);
    end

    // Windows look at the next counter values so the flags register in step
    jtpopeye_vtiming_win #(.W(HW), .START(HB_START), .STOP(HB_END)) u_hb (
        .pos    (h_nxt),
        .active (flags_nxt.hb)
    );

    jtpopeye_vtiming_win #(.W(VW), .START(VB_START), .STOP(VB_END)) u_vb (
        .pos    (v_nxt),
        .active (flags_nxt.vb)
    );

    jtpopeye_vtiming_win #(.W(HW), .START(HS_START), .STOP(HS_END)) u_hs (
        .pos    (h_nxt),
        .active (flags_nxt.hs)
    );

    jtpopeye_vtiming_win #(.W(VW), .START(VS_START), .STOP(VS_END)) u_vs (
        .pos    (v_nxt),
        .active (flags_nxt.vs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H     <= '0;
            V     <= '0;
            HB    <= 1'b0;
            VB    <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            hinit <= 1'b0;
            vinit <= 1'b0;
            odd   <= 1'b0;
        end else if (pxl_cen) begin
            H     <= h_nxt;
            V     <= v_nxt;
            HB    <= flags_nxt.hb;
            VB    <= flags_nxt.vb;
            HS    <= flags_nxt.hs;
            VS    <= flags_nxt.vs;
            hinit <= hinit_nxt;
            vinit <= vinit_nxt;
            odd   <= odd ^ vinit_nxt;
        end
    end

`ifdef JTPOPEYE_VTIMING_FLIP_EN
    // Flip only changes at frame start so a frame is never drawn half flipped
    logic flip_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_l <= 1'b0;
        end else if (pxl_cen && vinit_nxt) begin
            flip_l <= flip;
        end
    end

    assign Hf = H ^ {HW{flip_l}};
    assign Vf = V ^ {VW{flip_l}};
`else
    logic unused_flip;
    assign unused_flip = flip;

    assign Hf = H;
    assign Vf = V;
`endif

endmodule

// File: tb/tb_jtpopeye_vtiming.sv
// tb_jtpopeye_vtiming
// Randomized bench for jtpopeye_vtiming. Two instances share clk/rst_n/pxl_cen/
// flip: "A" uses a short 16-pixel line with the default vertical timing, "B"
// uses a 16x4 frame. The reference model derives every expected output from
// the number of enabled cycles since reset (H = n mod HTOTAL, and so on).
`timescale 1ns/1ps
module tb_jtpopeye_vtiming;

`ifdef JTPOPEYE_VTIMING_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    localparam int HTA = 16, VTA = 264;
    localparam int HTB = 16, VTB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic pxl_cen;
    logic flip;

    logic [8:0] ha, va, hfa, vfa, hb_b_h, hb_b_v;
    logic       hba, vba, hsa, vsa, hia, via, oda;
    logic [8:0] hfb, vfb;
    logic       hbb, vbb, hsb, vsb, hib, vib, odb;

    always #5 clk = ~clk;

    jtpopeye_vtiming #(
        .HTOTAL(HTA), .HB_START(12), .HB_END(0), .HS_START(13), .HS_END(15)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .H(ha), .V(va), .Hf(hfa), .Vf(vfa),
        .HB(hba), .VB(vba), .HS(hsa), .VS(vsa),
        .hinit(hia), .vinit(via), .odd(oda)
    );

    jtpopeye_vtiming #(
        .HTOTAL(HTB), .HB_START(12), .HB_END(0), .HS_START(13), .HS_END(15),
        .VTOTAL(VTB), .VB_START(3), .VB_END(1), .VS_START(2), .VS_END(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .H(hb_b_h), .V(hb_b_v), .Hf(hfb), .Vf(vfb),
        .HB(hbb), .VB(vbb), .HS(hsb), .VS(vsb),
        .hinit(hib), .vinit(vib), .odd(odb)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model state: enabled cycles since reset and the frame-latched flip
    int na = 0, nb = 0;
    bit fla = 1'b0, flb = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input int x, input int s, input int e);
        if (s > e) return (x >= s) || (x < e);
        return (x >= s) && (x < e);
    endfunction

    task automatic check_inst(
        input string nm, input int n, input bit fl,
        input int ht, input int vt,
        input int hbs, input int hbe, input int hss, input int hse,
        input int vbs, input int vbe, input int vss, input int vse,
        input int h, input int v, input int hf, input int vf,
        input bit hb, input bit vb, input bit hs, input bit vs,
        input bit hi, input bit vi, input bit od
    );
        int eh, ev, fr, mask;
        bit live;
        eh   = n % ht;
        ev   = (n / ht) % vt;
        fr   = n / (ht * vt);
        live = (n != 0);
        mask = (FLIP_EN && fl) ? 511 : 0;
        check_eq({nm, ".H"}, h, eh);
        check_eq({nm, ".V"}, v, ev);
        check_eq({nm, ".Hf"}, hf, eh ^ mask);
        check_eq({nm, ".Vf"}, vf, ev ^ mask);
        check_eq({nm, ".HB"}, int'(hb), int'(live && in_win(eh, hbs, hbe)));
        check_eq({nm, ".VB"}, int'(vb), int'(live && in_win(ev, vbs, vbe)));
        check_eq({nm, ".HS"}, int'(hs), int'(live && in_win(eh, hss, hse)));
        check_eq({nm, ".VS"}, int'(vs), int'(live && in_win(ev, vss, vse)));
        check_eq({nm, ".hinit"}, int'(hi), int'(live && eh == 0));
        check_eq({nm, ".vinit"}, int'(vi), int'(live && eh == 0 && ev == 0));
        check_eq({nm, ".odd"}, int'(od), fr % 2);
    endtask

    task automatic check_all();
        check_inst("A", na, fla, HTA, VTA, 12, 0, 13, 15, 240, 8, 244, 248,
                   int'(ha), int'(va), int'(hfa), int'(vfa),
                   hba, vba, hsa, vsa, hia, via, oda);
        check_inst("B", nb, flb, HTB, VTB, 12, 0, 13, 15, 3, 1, 2, 3,
                   int'(hb_b_h), int'(hb_b_v), int'(hfb), int'(vfb),
                   hbb, vbb, hsb, vsb, hib, vib, odb);
    endtask

    // One clock: drive inputs, advance the model on an enabled edge, then check
    task automatic step(input bit cen, input bit fl);
        pxl_cen = cen;
        flip    = fl;
        @(posedge clk);
        if (rst_n && cen) begin
            na++;
            if (na % (HTA * VTA) == 0) fla = fl;
            nb++;
            if (nb % (HTB * VTB) == 0) flb = fl;
        end
        #1;
        check_all();
    endtask

    function automatic int b_h();
        return nb % HTB;
    endfunction

    function automatic int b_v();
        return (nb / HTB) % VTB;
    endfunction

    initial begin
        int guard;
        bit fl_cur;

        rst_n   = 1'b0;
        pxl_cen = 1'b1;
        flip    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Random enable, no flip
        for (int i = 0; i < 300; i++) step(($urandom % 4) != 0, 1'b0);

        // Raise flip at B's V=2, H=7; it must only take effect at next frame start
        guard = 0;
        while (!(b_v() == 2 && b_h() == 7) && guard < 2000) begin
            step(($urandom % 3) != 0, 1'b0);
            guard++;
        end
        check_eq("reach_b_v2h7", int'(b_v() == 2 && b_h() == 7), 1);
        for (int i = 0; i < 200; i++) step(($urandom % 4) != 0, 1'b1);

        // Clock-enable gating at B's H=5
        guard = 0;
        while (b_h() != 5 && guard < 200) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_b_h5", b_h(), 5);
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i & 1));

        // Long random run: covers A's full vertical range twice, flip toggling
        fl_cur = 1'b1;
        for (int i = 0; i < 11000; i++) begin
            if (($urandom % 500) == 0) fl_cur = ~fl_cur;
            step(($urandom % 5) != 0, fl_cur);
        end

        // Asynchronous mid-frame reset at B's H=9, V=3
        guard = 0;
        while (!(b_h() == 9 && b_v() == 3) && guard < 2000) begin
            step(($urandom % 3) != 0, fl_cur);
            guard++;
        end
        check_eq("reach_b_h9v3", int'(b_h() == 9 && b_v() == 3), 1);
        #2;
        rst_n = 1'b0;
        na = 0; nb = 0; fla = 1'b0; flb = 1'b0;
        #1;
        check_all();
        step(1'b1, fl_cur);
        step(1'b0, fl_cur);
        #1;
        rst_n = 1'b1;
        step(1'b1, fl_cur);
        check_eq("first_h_after_reset", int'(hb_b_h), 1);
        for (int i = 0; i < 100; i++) step(($urandom % 2) != 0, fl_cur);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtpopeye_vtiming.md
JTPOPEYE_VTIMING -- requirements
Module: jtpopeye_vtiming

Interface
REQ-001 SHALL have parameter HW, default 9: H counter width in bits.
REQ-002 SHALL have parameter VW, default 9: V counter width in bits.
REQ-003 SHALL have parameters HTOTAL=384, HB_START=256, HB_END=0, HS_START=300, HS_END=332: pixels per line and H blank/sync edges.
REQ-004 SHALL have parameters VTOTAL=264, VB_START=240, VB_END=8, VS_START=244, VS_END=248: lines per frame and V blank/sync edges.
REQ-005 SHALL have port clk, input, 1 bit: single system clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pxl_cen, input, 1 bit: pixel clock enable.
REQ-008 SHALL have port flip, input, 1 bit: screen flip request.
REQ-009 SHALL have ports H and V, outputs, HW and VW bits: raw pixel and line counters.
REQ-010 SHALL have ports Hf and Vf, outputs, HW and VW bits: flip-adjusted counters.
REQ-011 SHALL have ports HB, VB, HS, VS, outputs, 1 bit each: active-high blank and sync.
REQ-012 SHALL have ports hinit and vinit, outputs, 1 bit each: line-start and frame-start strobes.
REQ-013 SHALL have port odd, output, 1 bit: frame parity, toggling every frame.

Function
REQ-014 SHALL update every register only on clk rising edges where pxl_cen=1, and SHALL hold all state otherwise.
REQ-015 SHALL increment H by 1 per enabled cycle and SHALL wrap it to 0 after HTOTAL-1.
REQ-016 SHALL increment V on the enabled cycle where H wraps, and SHALL wrap V to 0 after VTOTAL-1.
REQ-017 SHALL register HB, HS, VB and VS, each consistent with the H/V values presented in the same cycle, with zero lag.
REQ-018 SHALL set HB=1 when H=HB_START and clear it when H=HB_END; VB SHALL follow the same rule on V with VB_START and VB_END.
REQ-019 SHALL handle blank windows whose start exceeds their end as windows that wrap through 0.
REQ-020 SHALL set HS=1 for HS_START<=H<HS_END, and VS=1 for VS_START<=V<VS_END.
REQ-021 SHALL assert hinit for exactly one pxl_cen period, in the cycle H=0.
REQ-022 SHALL assert vinit for exactly one pxl_cen period, in the cycle H=0 and V=0.
REQ-023 SHALL toggle odd on each vinit.
REQ-024 SHALL sample flip into an internal flip_l register only at vinit, so a flip change never takes effect mid-frame.
REQ-025 SHALL drive Hf=H^{HW{flip_l}} and Vf=V^{VW{flip_l}}.
REQ-026 SHALL cause an illegal parameter set (any edge >= its TOTAL, or TOTAL > 2^width) to fail elaboration.

Reset
REQ-027 SHALL, while rst_n=0, force H=0, V=0, HB=0, VB=0, HS=0, VS=0, hinit=0, vinit=0, odd=0 and flip_l=0, regardless of pxl_cen.
REQ-028 SHALL, on the first enabled cycle after reset release, present H=1, V=0, with blank and sync decoded from those values.
REQ-029 SHALL apply a mid-frame reset immediately and asynchronously, with no partial-line completion.

Configuration
REQ-030 SHALL, when JTPOPEYE_VTIMING_FLIP_EN is defined, implement the flip behaviour of REQ-024 and REQ-025.
REQ-031 SHALL, when JTPOPEYE_VTIMING_FLIP_EN is undefined, ignore flip, tie Hf=H and Vf=V, and omit the flip_l register.

Structure
REQ-032 SHALL place default timing constants (HTOTAL, VTOTAL, blank and sync edges) in shared package jtpopeye_pkg.
REQ-033 SHALL use one sub-module, jtpopeye_vtiming_win: a generic window comparator instantiated for HB, VB, HS and VS.

Verification
REQ-034 SHALL test H wrap: with HTOTAL=16, HB_START=12, HB_END=0, run 40 enabled cycles -> H wraps 15->0, HB=1 for H=12..15, hinit high at each H=0.
REQ-035 SHALL test V wrap: with VTOTAL=4, run 64 enabled cycles -> V steps 0..3 and wraps, vinit pulses every 64 cycles, odd toggles on each vinit.
REQ-036 SHALL test clock-enable gating: hold pxl_cen=0 for 10 clk with H=5 -> H stays 5 and all outputs are stable.
REQ-037 SHALL test flip timing: raise flip at V=2, H=7 -> Hf=H until the next vinit, then Hf=~H and Vf=~V; with the macro undefined, Hf=H always.
REQ-038 SHALL test reset: assert rst_n=0 at H=9, V=3 without a clk edge -> H=0, V=0 and all flags 0 immediately; after release, first enabled cycle gives H=1.
REQ-039 SHALL test a wrapped window: with VB_START=240, VB_END=8 and defaults -> VB=1 for V>=240 or V<8 and 0 otherwise, with VS=1 for V=244..247.
